// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and register map for mmio_uart_tx (UART_PARITY_EN adds the PARITY state)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped FIFO-fed UART transmitter, 8N1 or 8E1 when UART_PARITY_EN is defined
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e   state_q, state_d;
    logic [15:0]   div_q;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   reload;
    logic          tick;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    fifo_data;
    logic          wr_data;
    logic          wr_status;
    logic          wr_div;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel       = (a[31:4] == BASE_ADDR[31:4]);
    assign wr_data   = we && sel && (a[3:2] == REG_DATA);
    assign wr_status = we && sel && (a[3:2] == REG_STATUS);
    assign wr_div    = we && sel && (a[3:2] == REG_DIV);
    assign unused_bits = ^{a[1:0], wd[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (reset),
        .push   (wr_data),
        .wdata  (wd[7:0]),
        .pop    (pop),
        .rdata  (fifo_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= DEFAULT_DIV;
            ovf_q <= 1'b0;
        end else begin
            if (wr_div) begin
                div_q <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
            end
            if (wr_data && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (wr_status && wd[STAT_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign reload = div_q - 16'd1;
    assign tick   = (baud_q == 16'd0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    state_d = ST_START;
                    baud_d  = reload;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    baud_d  = reload;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    baud_d = reload;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    baud_d  = reload;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The shift register is indexed rather than shifted so parity can see all 8 bits.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = ^shift_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx  = tx_q;
    assign irq = empty && (state_q == ST_IDLE);

    always_comb begin
        status                         = 32'd0;
        status[STAT_BUSY]              = (state_q != ST_IDLE);
        status[STAT_FULL]              = full;
        status[STAT_EMPTY]             = empty;
        status[STAT_OVF]               = ovf_q;
        status[STAT_COUNT_LSB +: 8]    = 8'(count);
    end

    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (a[3:2])
                REG_STATUS: rd = status;
                REG_DIV:    rd = {16'd0, div_q};
                default:    rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx (honours UART_PARITY_EN)
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] a     = 32'd0;
    logic [31:0] wd    = 32'd0;
    logic [31:0] rd;
    logic        sel;
    logic        tx;
    logic        irq;

    int          tests   = 0;
    int          fails   = 0;
    int          rx_err  = 0;
    int          mon_div = 4;
    logic [7:0]  rx_q[$];

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .sel   (sel),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        a  = addr;
        we = 1'b0;
        #1;
        data = rd;
    endtask

    task automatic expect_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus_read(addr, r);
        check(tag, r, exp);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(irq), 32'd1);
    endtask

    function automatic logic [31:0] pop_rx();
        if (rx_q.size() == 0) return 32'hFFFF_FFFF;
        return 32'(rx_q.pop_front());
    endfunction

    // Called on the first START cycle; samples every cycle of the frame.
    task automatic capture_frame(input string tag, input int div, input logic [7:0] data);
        logic [10:0] exp_bits;
        logic [10:0] got_bits;
        int          bad;
        exp_bits = {1'b1, 1'b1, data, 1'b0};
`ifdef UART_PARITY_EN
        exp_bits[9] = ^data;
`endif
        got_bits = '1;
        bad      = 0;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < div; c++) begin
                if (c == 0) got_bits[i] = tx;
                if (tx !== exp_bits[i]) bad++;
                @(posedge clk);
                #1;
            end
        end
        check({tag, "_bits"}, 32'(got_bits), 32'(exp_bits));
        check({tag, "_badcycles"}, 32'(bad), 32'd0);
        check({tag, "_tx_after"}, 32'(tx), 32'd1);
    endtask

    initial begin : rx_monitor
        logic [10:0] bits;
        logic        aborted;
        forever begin
            @(posedge clk);
            #1;
            if (reset && tx === 1'b0) begin
                bits    = '1;
                bits[0] = tx;
                aborted = 1'b0;
                for (int k = 1; k < NB * mon_div; k++) begin
                    @(posedge clk);
                    #1;
                    if (!reset) aborted = 1'b1;
                    if (k % mon_div == mon_div / 2) bits[k / mon_div] = tx;
                end
                if (!aborted) begin
                    rx_q.push_back(bits[8:1]);
                    if (bits[NB-1] !== 1'b1) rx_err++;
`ifdef UART_PARITY_EN
                    if (bits[9] !== ^bits[8:1]) rx_err++;
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] r;
        int          lows;

        // reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t1_tx", 32'(tx), 32'd1);
        check("t1_irq", 32'(irq), 32'd1);
        expect_reg("t1_status", BASE + 32'h4, 32'h0000_0004);
        check("t1_sel", 32'(sel), 32'd1);
        expect_reg("t1_div", BASE + 32'h8, 32'h0000_01B2);
        expect_reg("t1_data_rd", BASE + 32'h0, 32'h0);
        expect_reg("t1_resv_rd", BASE + 32'hC, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single frame, DIV=4, 0x55
        bus_write(BASE + 32'h8, 32'd4);
        mon_div = 4;
        rx_q.delete();
        bus_write(BASE, 32'h55);
        check("t2_tx_pre", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        capture_frame("t2", 4, 8'h55);
        expect_reg("t2_status_idle", BASE + 32'h4, 32'h0000_0004);
        check("t2_irq", 32'(irq), 32'd1);
        check("t2_rx", pop_rx(), 32'h55);

        // overflow: 10 back-to-back writes
        rx_q.delete();
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'(i));
        expect_reg("t3_status_full", BASE + 32'h4, 32'h0000_080B);
        bus_write(BASE + 32'h4, 32'h8);
        expect_reg("t3_status_clr", BASE + 32'h4, 32'h0000_0803);
        // land a push on the same edge as the pop of byte 0x01 while full
        repeat (31) @(posedge clk);
        #1;
        bus_write(BASE, 32'h0A);
        expect_reg("t3_push_pop_full", BASE + 32'h4, 32'h0000_0803);
        wait_idle("t3_drain", 2000);
        check("t3_rx_count", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 9; i++) check($sformatf("t3_rx%0d", i), pop_rx(), 32'(i));
        check("t3_rx_last", pop_rx(), 32'h0A);
        expect_reg("t3_status_end", BASE + 32'h4, 32'h0000_0004);

        // reset during data bit 3
        rx_q.delete();
        bus_write(BASE, 32'hA5);
        bus_write(BASE, 32'h3C);
        repeat (16) @(posedge clk);
        #1;
        check("t4_bit3_low", 32'(tx), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t4_tx_reset", 32'(tx), 32'd1);
        expect_reg("t4_status", BASE + 32'h4, 32'h0000_0004);
        expect_reg("t4_div", BASE + 32'h8, 32'd434);
        reset = 1'b1;
        lows = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("t4_no_frames", 32'(lows), 32'd0);
        check("t4_rx_none", 32'(rx_q.size()), 32'd0);

        // out-of-window writes, DIV=0
        bus_write(BASE + 32'h10, 32'h77);
        bus_write(BASE + 32'h18, 32'h5);
        bus_write(32'h0000_0000, 32'h11);
        bus_write(32'h0000_0008, 32'h0);
        bus_read(BASE + 32'h18, r);
        check("t5_sel_hi", 32'(sel), 32'd0);
        check("t5_rd_hi", r, 32'd0);
        bus_read(32'h0000_0000, r);
        check("t5_sel_zero", 32'(sel), 32'd0);
        check("t5_rd_zero", r, 32'd0);
        expect_reg("t5_status", BASE + 32'h4, 32'h0000_0004);
        expect_reg("t5_div", BASE + 32'h8, 32'd434);
        bus_write(BASE + 32'h8, 32'd0);
        expect_reg("t5_div_zero", BASE + 32'h8, 32'd1);
        mon_div = 1;
        rx_q.delete();
        bus_write(BASE, 32'hC3);
        @(posedge clk);
        #1;
        capture_frame("t5", 1, 8'hC3);
        wait_idle("t5_idle", 100);
        check("t5_rx", pop_rx(), 32'hC3);

`ifdef UART_PARITY_EN
        bus_write(BASE + 32'h8, 32'd4);
        mon_div = 4;
        rx_q.delete();
        bus_write(BASE, 32'h07);
        @(posedge clk);
        #1;
        capture_frame("t6", 4, 8'h07);
        check("t6_rx", pop_rx(), 32'h07);
`endif

        check("rx_framing", 32'(rx_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
